// File: rtl/mux_serializer_pkg.sv
// ---------------------------------------------------------------------------
// ser_pkg
//
// Shared definitions for the byte-to-bit serializer.
//
// Contents:
//    IDLE / SHIFT / PARITY   - FSM state encoding (2-bit localparams)
//    BYTE_W / SEL_W          - data word width and mux select width
//    bit_first(msb_first)    - select value of the first bit sent
//    bit_final(msb_first)    - select value of the last data bit sent
//    bit_step(sel, msb)      - select value of the next data bit
// ---------------------------------------------------------------------------
package ser_pkg;

   localparam int BYTE_W = 8;
   localparam int SEL_W  = 3;

   // FSM state encoding; PARITY is only ever entered when parity is enabled
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;

   // LSB-first walks the select upwards from 0, MSB-first walks it down from 7
   function automatic logic [SEL_W-1:0] bit_first(input int msb_first);
      return (msb_first != 0) ? 3'd7 : 3'd0;
   endfunction

   function automatic logic [SEL_W-1:0] bit_final(input int msb_first);
      return (msb_first != 0) ? 3'd0 : 3'd7;
   endfunction

   function automatic logic [SEL_W-1:0] bit_step(input logic [SEL_W-1:0] sel,
                                                 input int                msb_first);
      return (msb_first != 0) ? (sel - 3'd1) : (sel + 3'd1);
   endfunction

endpackage

// File: rtl/mux_8x1.sv
// ---------------------------------------------------------------------------
// mux_8x1
//
// Plain 8-to-1 bit multiplexer. Picks one bit of an 8-bit word.
//
// Ports:
//    in   [7:0]  word to select from
//    sel  [2:0]  index of the bit to pass through
//    out         selected bit, in[sel]
// ---------------------------------------------------------------------------
module mux_8x1 (
   input  logic [7:0] in,
   input  logic [2:0] sel,
   output logic       out
);

   // Fully decoded selection so every select value has a defined output
   always_comb begin
      out = 1'b0;
      case (sel)
         3'd0:    out = in[0];
         3'd1:    out = in[1];
         3'd2:    out = in[2];
         3'd3:    out = in[3];
         3'd4:    out = in[4];
         3'd5:    out = in[5];
         3'd6:    out = in[6];
         3'd7:    out = in[7];
         default: out = 1'b0;
      endcase
   end

endmodule

// File: rtl/mux_serializer.sv
// ---------------------------------------------------------------------------
// mux_serializer
//
// Byte-to-bit parallel-in / serial-out serializer. One 8-bit word is taken
// per din valid/ready handshake and emitted one bit per accepted beat on the
// ser valid/ready stream, optionally followed by an even-parity beat.
// A 3-bit bit index drives the select of a mux_8x1 that picks the current
// bit out of the held word.
//
// Parameters:
//    MSB_FIRST  0: bits go out 0..7, 1: bits go out 7..0
//    PARITY_EN  1: append a 9th beat carrying XOR of the 8 data bits
//
// Ports:
//    clk        system clock, rising edge
//    rst_n      asynchronous active-low reset
//    din        parallel word to serialize
//    din_valid  din is valid
//    din_ready  serializer can accept din this cycle
//    ser_out    current serial bit
//    ser_valid  ser_out is valid
//    ser_ready  downstream accepts ser_out this cycle
//    ser_last   current beat is the final beat of the word
//    bit_sel    current mux select (debug / observation)
//    busy       a word is in flight
// ---------------------------------------------------------------------------
module mux_serializer
   import ser_pkg::*;
#(
   parameter int MSB_FIRST = 0,
   parameter int PARITY_EN = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       ser_out,
   output logic       ser_valid,
   input  logic       ser_ready,
   output logic       ser_last,
   output logic [2:0] bit_sel,
   output logic       busy
);

   localparam logic [SEL_W-1:0] BIT_FIRST = bit_first(MSB_FIRST);
   localparam logic [SEL_W-1:0] BIT_FINAL = bit_final(MSB_FIRST);
   localparam bit               PAR_ON    = (PARITY_EN != 0);

   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic [BYTE_W-1:0] data_q;
   logic [BYTE_W-1:0] data_d;
   logic [SEL_W-1:0]  sel_q;
   logic [SEL_W-1:0]  sel_d;

   logic mux_bit;
   logic load;
   logic beat;
   logic at_final;
   logic word_done;

   // Bit picker: the held word feeds the mux, the bit index is its select
   mux_8x1 u_mux (
      .in  (data_q),
      .sel (sel_q),
      .out (mux_bit)
   );

   // Stream status is decoded purely from registered state, so ser_valid,
   // ser_last and busy never glitch with din or ser_ready
   always_comb begin
      at_final  = (sel_q == BIT_FINAL);
      ser_valid = (state_q != IDLE);
      busy      = (state_q != IDLE);
      ser_last  = ((state_q == SHIFT) && at_final && !PAR_ON) ||
                  (state_q == PARITY);
      bit_sel   = sel_q;
   end

   // Handshakes. din_ready also opens on the final beat of a word so that the
   // next word loads on the same edge and the stream has no idle bubble.
   // It is held low while reset is asserted.
   always_comb begin
      beat      = ser_valid && ser_ready;
      word_done = beat && ser_last;
      din_ready = rst_n && ((state_q == IDLE) || word_done);
      load      = din_valid && din_ready;
   end

   // Serial data: data bits come through the mux, the parity beat is the
   // XOR of the held word, and nothing is driven while idle
   always_comb begin
      ser_out = 1'b0;
      case (state_q)
         SHIFT:   ser_out = mux_bit;
         PARITY:  ser_out = ^data_q;
         default: ser_out = 1'b0;
      endcase
   end

   // Next-state logic. Everything holds unless a load or a beat happens,
   // which gives the required stability under backpressure. The held word
   // is only ever replaced by a load, never part way through a word.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               data_d  = din;
               sel_d   = BIT_FIRST;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (beat) begin
               if (!at_final) begin
                  sel_d = bit_step(sel_q, MSB_FIRST);
               end else if (PAR_ON) begin
                  state_d = PARITY;
               end else if (load) begin
                  data_d  = din;
                  sel_d   = BIT_FIRST;
                  state_d = SHIFT;
               end else begin
                  sel_d   = 3'd0;
                  state_d = IDLE;
               end
            end
         end
         PARITY: begin
            if (beat) begin
               if (load) begin
                  data_d  = din;
                  sel_d   = BIT_FIRST;
                  state_d = SHIFT;
               end else begin
                  sel_d   = 3'd0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            sel_d   = 3'd0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers. Reset drops any word in flight immediately, so no
   // partial beat can appear after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= 8'h00;
         sel_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

endmodule

// File: tb/tb_mux_serializer.sv
// ---------------------------------------------------------------------------
// tb_mux_serializer
//
// Self-checking bench for mux_serializer. Three instances share clock and
// reset: index 0 is LSB-first without parity, index 1 is MSB-first without
// parity, index 2 is LSB-first with parity. Expected bits come from a small
// reference model describing which bit of the word belongs to which beat.
// ---------------------------------------------------------------------------
module tb_mux_serializer;

   logic       clk;
   logic       rst_n;
   logic [7:0] din [3];
   logic [2:0] din_valid;
   logic [2:0] din_ready;
   logic [2:0] ser_out;
   logic [2:0] ser_valid;
   logic [2:0] ser_ready;
   logic [2:0] ser_last;
   logic [2:0] bit_sel [3];
   logic [2:0] busy;

   int total;
   int bad;

   // One instance per parameter combination of interest
   for (genvar g = 0; g < 3; g++) begin : g_dut
      mux_serializer #(
         .MSB_FIRST ((g == 1) ? 1 : 0),
         .PARITY_EN ((g == 2) ? 1 : 0)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .din       (din[g]),
         .din_valid (din_valid[g]),
         .din_ready (din_ready[g]),
         .ser_out   (ser_out[g]),
         .ser_valid (ser_valid[g]),
         .ser_ready (ser_ready[g]),
         .ser_last  (ser_last[g]),
         .bit_sel   (bit_sel[g]),
         .busy      (busy[g])
      );
   end

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: word layout on the serial stream for each instance
   function automatic int msb_of(input int i);
      return (i == 1) ? 1 : 0;
   endfunction

   function automatic int beats_of(input int i);
      return (i == 2) ? 9 : 8;
   endfunction

   function automatic logic exp_bit(input int i, input logic [7:0] w, input int k);
      if (k >= 8) return ^w;
      return (msb_of(i) != 0) ? w[7-k] : w[k];
   endfunction

   function automatic logic [2:0] exp_sel(input int i, input int k);
      return (msb_of(i) != 0) ? 3'(7 - k) : 3'(k);
   endfunction

   // Move to just after the next rising edge, where inputs are changed
   task automatic next_cycle;
      @(posedge clk);
      #2;
   endtask

   // Outputs are at reset values while reset is held, ready opens on release
   task automatic test_reset;
      rst_n     = 1'b0;
      din_valid = 3'b000;
      ser_ready = 3'b000;
      for (int i = 0; i < 3; i++) din[i] = 8'h00;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (ser_valid[i] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ser_valid[%0d] got=%b want=0", i, ser_valid[i]);
         end
         total++;
         if (busy[i] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_busy[%0d] got=%b want=0", i, busy[i]);
         end
         total++;
         if (bit_sel[i] !== 3'd0) begin
            bad++;
            $display("[TB] FAIL reset_bit_sel[%0d] got=%0d want=0", i, bit_sel[i]);
         end
         total++;
         if (ser_out[i] !== 1'b0 || ser_last[i] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_out_last[%0d] got=%b%b want=00", i, ser_out[i], ser_last[i]);
         end
      end
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (din_ready[i] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_release_ready[%0d] got=%b want=1", i, din_ready[i]);
         end
      end
   endtask

   // LSB-first word with a free-running sink
   task automatic test_basic_lsb;
      logic [7:0] w;
      w = 8'hA5;
      next_cycle();
      din[0] = w; din_valid[0] = 1'b1; ser_ready[0] = 1'b1;
      @(negedge clk);
      total++;
      if (din_ready[0] !== 1'b1) begin
         bad++;
         $display("[TB] FAIL lsb_load_ready got=%b want=1", din_ready[0]);
      end
      next_cycle();
      din_valid[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         total++;
         if (ser_valid[0] !== 1'b1 || ser_out[0] !== exp_bit(0, w, k) ||
             ser_last[0] !== (k == 7) || bit_sel[0] !== exp_sel(0, k)) begin
            bad++;
            $display("[TB] FAIL lsb_beat%0d got v=%b o=%b l=%b s=%0d want v=1 o=%b l=%b s=%0d",
                     k, ser_valid[0], ser_out[0], ser_last[0], bit_sel[0],
                     exp_bit(0, w, k), (k == 7), exp_sel(0, k));
         end
         next_cycle();
      end
      @(negedge clk);
      total++;
      if (ser_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         bad++;
         $display("[TB] FAIL lsb_idle got v=%b busy=%b want 0 0", ser_valid[0], busy[0]);
      end
   endtask

   // MSB-first words, select counting down
   task automatic test_msb_first;
      logic [7:0] words [2];
      words[0] = 8'hA5;
      words[1] = 8'h01;
      for (int n = 0; n < 2; n++) begin
         next_cycle();
         din[1] = words[n]; din_valid[1] = 1'b1; ser_ready[1] = 1'b1;
         @(negedge clk);
         total++;
         if (din_ready[1] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL msb_load_ready got=%b want=1", din_ready[1]);
         end
         next_cycle();
         din_valid[1] = 1'b0;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (ser_valid[1] !== 1'b1 || ser_out[1] !== exp_bit(1, words[n], k) ||
                ser_last[1] !== (k == 7) || bit_sel[1] !== exp_sel(1, k)) begin
               bad++;
               $display("[TB] FAIL msb_w%0d_beat%0d got v=%b o=%b l=%b s=%0d want v=1 o=%b l=%b s=%0d",
                        n, k, ser_valid[1], ser_out[1], ser_last[1], bit_sel[1],
                        exp_bit(1, words[n], k), (k == 7), exp_sel(1, k));
            end
            next_cycle();
         end
         @(negedge clk);
         total++;
         if (ser_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL msb_idle got v=%b busy=%b want 0 0", ser_valid[1], busy[1]);
         end
      end
   endtask

   // Sink stalls for 3 cycles while bit 2 is presented
   task automatic test_backpressure;
      logic [7:0] w;
      int         k;
      int         stall;
      int         cycles;
      w = 8'h3C;
      next_cycle();
      din[0] = w; din_valid[0] = 1'b1; ser_ready[0] = 1'b1;
      @(negedge clk);
      next_cycle();
      din_valid[0] = 1'b0;
      k = 0; stall = 0; cycles = 0;
      while (k < 8 && cycles < 40) begin
         if (k == 2 && stall < 3) begin
            ser_ready[0] = 1'b0;
            stall++;
         end else begin
            ser_ready[0] = 1'b1;
         end
         @(negedge clk);
         cycles++;
         total++;
         if (ser_valid[0] !== 1'b1 || ser_out[0] !== exp_bit(0, w, k) ||
             bit_sel[0] !== exp_sel(0, k)) begin
            bad++;
            $display("[TB] FAIL bp_cycle%0d got v=%b o=%b s=%0d want v=1 o=%b s=%0d",
                     cycles, ser_valid[0], ser_out[0], bit_sel[0], exp_bit(0, w, k), exp_sel(0, k));
         end
         if (ser_ready[0]) begin
            total++;
            if (ser_last[0] !== (k == 7)) begin
               bad++;
               $display("[TB] FAIL bp_last_beat%0d got=%b want=%b", k, ser_last[0], (k == 7));
            end
            k++;
         end
         next_cycle();
      end
      ser_ready[0] = 1'b1;
      total++;
      if (cycles !== 11 || k !== 8) begin
         bad++;
         $display("[TB] FAIL bp_duration got cycles=%0d beats=%0d want cycles=11 beats=8", cycles, k);
      end
   endtask

   // Two words with din_valid held high: 16 contiguous beats
   task automatic test_back_to_back;
      next_cycle();
      din[0] = 8'hFF; din_valid[0] = 1'b1; ser_ready[0] = 1'b1;
      @(negedge clk);
      total++;
      if (din_ready[0] !== 1'b1) begin
         bad++;
         $display("[TB] FAIL b2b_first_ready got=%b want=1", din_ready[0]);
      end
      next_cycle();
      din[0] = 8'h00;
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         total++;
         if (ser_valid[0] !== 1'b1 || ser_out[0] !== (n < 8) ||
             ser_last[0] !== (n == 7 || n == 15) ||
             din_ready[0] !== (n == 7 || n == 15)) begin
            bad++;
            $display("[TB] FAIL b2b_beat%0d got v=%b o=%b l=%b r=%b want v=1 o=%b l=%b r=%b",
                     n, ser_valid[0], ser_out[0], ser_last[0], din_ready[0],
                     (n < 8), (n == 7 || n == 15), (n == 7 || n == 15));
         end
         next_cycle();
         if (n == 7) din_valid[0] = 1'b0;
      end
      @(negedge clk);
      total++;
      if (ser_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_idle got v=%b busy=%b want 0 0", ser_valid[0], busy[0]);
      end
   endtask

   // Parity instance: 9 beats, last one is XOR of the data bits
   task automatic test_parity;
      logic [7:0] words [2];
      words[0] = 8'h07;
      words[1] = 8'h03;
      for (int n = 0; n < 2; n++) begin
         next_cycle();
         din[2] = words[n]; din_valid[2] = 1'b1; ser_ready[2] = 1'b1;
         @(negedge clk);
         next_cycle();
         din_valid[2] = 1'b0;
         for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            total++;
            if (ser_valid[2] !== 1'b1 || ser_out[2] !== exp_bit(2, words[n], k) ||
                ser_last[2] !== (k == 8)) begin
               bad++;
               $display("[TB] FAIL par_w%0d_beat%0d got v=%b o=%b l=%b want v=1 o=%b l=%b",
                        n, k, ser_valid[2], ser_out[2], ser_last[2],
                        exp_bit(2, words[n], k), (k == 8));
            end
            next_cycle();
         end
         @(negedge clk);
         total++;
         if (ser_valid[2] !== 1'b0 || busy[2] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL par_idle got v=%b busy=%b want 0 0", ser_valid[2], busy[2]);
         end
      end
   endtask

   // Asynchronous reset during bit 4, then a clean word afterwards
   task automatic test_reset_mid_word;
      logic [7:0] w;
      w = 8'hA5;
      next_cycle();
      din[0] = w; din_valid[0] = 1'b1; ser_ready[0] = 1'b1;
      @(negedge clk);
      next_cycle();
      din_valid[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         next_cycle();
      end
      @(negedge clk);
      total++;
      if (bit_sel[0] !== exp_sel(0, 4) || ser_valid[0] !== 1'b1) begin
         bad++;
         $display("[TB] FAIL rst_mid_position got s=%0d v=%b want s=4 v=1", bit_sel[0], ser_valid[0]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (ser_valid[0] !== 1'b0 || busy[0] !== 1'b0 || bit_sel[0] !== 3'd0 || ser_out[0] !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rst_mid_async got v=%b busy=%b s=%0d o=%b want 0 0 0 0",
                  ser_valid[0], busy[0], bit_sel[0], ser_out[0]);
      end
      next_cycle();
      rst_n = 1'b1;
      w = 8'h5A;
      din[0] = w; din_valid[0] = 1'b1;
      @(negedge clk);
      total++;
      if (din_ready[0] !== 1'b1 || ser_valid[0] !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rst_mid_release got r=%b v=%b want r=1 v=0", din_ready[0], ser_valid[0]);
      end
      next_cycle();
      din_valid[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         total++;
         if (ser_valid[0] !== 1'b1 || ser_out[0] !== exp_bit(0, w, k) ||
             ser_last[0] !== (k == 7) || bit_sel[0] !== exp_sel(0, k)) begin
            bad++;
            $display("[TB] FAIL rst_mid_next_beat%0d got v=%b o=%b l=%b s=%0d want v=1 o=%b l=%b s=%0d",
                     k, ser_valid[0], ser_out[0], ser_last[0], bit_sel[0],
                     exp_bit(0, w, k), (k == 7), exp_sel(0, k));
         end
         next_cycle();
      end
   endtask

   // Random words, random gaps and random sink stalls on every instance.
   // The scoreboard holds (word, beat index) pairs still owed by the DUT.
   task automatic test_random;
      logic [7:0] qw [$];
      int         qk [$];
      int         sent;
      int         cycles;
      logic       exp_ready;
      logic       model_beat;
      for (int i = 0; i < 3; i++) begin
         qw.delete();
         qk.delete();
         sent   = 0;
         cycles = 0;
         while (!(sent == 6 && qk.size() == 0 && din_valid[i] == 1'b0) && cycles < 600) begin
            next_cycle();
            cycles++;
            if (din_valid[i] == 1'b0 && sent < 6 && $urandom_range(0, 3) != 0) begin
               din[i]       = 8'($urandom);
               din_valid[i] = 1'b1;
            end
            ser_ready[i] = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (qk.size() > 0) begin
               total++;
               if (ser_valid[i] !== 1'b1 || ser_out[i] !== exp_bit(i, qw[0], qk[0]) ||
                   ser_last[i] !== (qk[0] == beats_of(i) - 1) ||
                   (qk[0] < 8 && bit_sel[i] !== exp_sel(i, qk[0]))) begin
                  bad++;
                  $display("[TB] FAIL rnd%0d_word%02h_beat%0d got v=%b o=%b l=%b s=%0d want v=1 o=%b l=%b",
                           i, qw[0], qk[0], ser_valid[i], ser_out[i], ser_last[i], bit_sel[i],
                           exp_bit(i, qw[0], qk[0]), (qk[0] == beats_of(i) - 1));
               end
            end else begin
               total++;
               if (ser_valid[i] !== 1'b0) begin
                  bad++;
                  $display("[TB] FAIL rnd%0d_spurious_valid got=%b want=0", i, ser_valid[i]);
               end
            end
            model_beat = (qk.size() > 0) && ser_ready[i];
            exp_ready  = (qk.size() == 0) || (model_beat && qk[0] == beats_of(i) - 1);
            total++;
            if (din_ready[i] !== exp_ready) begin
               bad++;
               $display("[TB] FAIL rnd%0d_din_ready got=%b want=%b", i, din_ready[i], exp_ready);
            end
            if (model_beat) begin
               void'(qw.pop_front());
               void'(qk.pop_front());
            end
            if (din_valid[i] && exp_ready) begin
               for (int k = 0; k < beats_of(i); k++) begin
                  qw.push_back(din[i]);
                  qk.push_back(k);
               end
               sent++;
               next_cycle();
               cycles++;
               din_valid[i] = 1'b0;
               ser_ready[i] = ($urandom_range(0, 2) != 0);
               @(negedge clk);
               total++;
               if (ser_valid[i] !== 1'b1 || ser_out[i] !== exp_bit(i, qw[0], qk[0])) begin
                  bad++;
                  $display("[TB] FAIL rnd%0d_after_load got v=%b o=%b want v=1 o=%b",
                           i, ser_valid[i], ser_out[i], exp_bit(i, qw[0], qk[0]));
               end
               if (ser_ready[i]) begin
                  if (qk[0] == beats_of(i) - 1) begin
                     total++;
                     if (din_ready[i] !== 1'b1) begin
                        bad++;
                        $display("[TB] FAIL rnd%0d_din_ready_last got=%b want=1", i, din_ready[i]);
                     end
                  end
                  void'(qw.pop_front());
                  void'(qk.pop_front());
               end
            end
         end
         total++;
         if (cycles >= 600) begin
            bad++;
            $display("[TB] FAIL rnd%0d_timeout got cycles=%0d want below 600 (sent=%0d pending=%0d)",
                     i, cycles, sent, qk.size());
         end
         din_valid[i] = 1'b0;
         ser_ready[i] = 1'b1;
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      $display("[TB] starting mux_serializer bench");
      test_reset();
      test_basic_lsb();
      test_msb_first();
      test_backpressure();
      test_back_to_back();
      test_parity();
      test_reset_mid_word();
      test_random();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_serializer.md
Name: mux_serializer

Overview:
- Byte-to-bit parallel-in/serial-out serializer. Accepts one 8-bit word per valid/ready handshake and emits it one bit per accepted beat on a serial valid/ready stream.
- Internally, a 3-bit bit-index counter drives the `sel` of an instantiated `mux_8x1`, which picks the current bit from the held word.
- Sits directly upstream of the mux, generating its select sequence. It sits downstream of any byte producer (register file, UART TX path).

Parameters:
- MSB_FIRST, 0 — 0: send bits in order 0..7 (sel counts up); 1: send bits in order 7..0 (sel counts down).
- PARITY_EN, 0 — 1: append a 9th beat carrying even parity (XOR of the 8 data bits).

Ports:
- clk  in  1  — system clock, rising edge.
- rst_n  in  1  — asynchronous active-low reset.
- din  in  8  — parallel word to serialize.
- din_valid  in  1  — din is valid.
- din_ready  out  1  — serializer can accept din this cycle.
- ser_out  out  1  — current serial bit.
- ser_valid  out  1  — ser_out is valid.
- ser_ready  in  1  — downstream accepts ser_out this cycle.
- ser_last  out  1  — current beat is the final beat of the word.
- bit_sel  out  3  — current mux select, for debug/observation.
- busy  out  1  — a word is in flight (state != IDLE).

Behaviour:
- Clock and reset are fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE; data_q=8'h00; bit_sel=0; ser_valid=0; ser_last=0; busy=0; ser_out=0.
  - din_ready=1 once rst_n is high.
- FSM states: IDLE, SHIFT, PARITY.
  - PARITY is unreachable when PARITY_EN=0.
- Handshake definitions:
  - Load = din_valid && din_ready.
  - Beat = ser_valid && ser_ready.
- din_ready = (state==IDLE) || (Beat && ser_last). It is combinational from ser_ready, so back-to-back words have no bubble.
- Load edge:
  - data_q <= din.
  - bit_sel <= (MSB_FIRST ? 7 : 0).
  - state <= SHIFT.
  - ser_valid is high the following cycle. First-bit latency is 1 clock after the load edge.
- ser_out behaviour:
  - In SHIFT: ser_out = mux_8x1(data_q, bit_sel).
  - In PARITY: ser_out = ^data_q.
  - ser_out is driven only from registers; there is no combinational path from din.
- Backpressure: while ser_valid && !ser_ready, ser_out, bit_sel and ser_last hold stable. The AXI-style rule applies: no retraction once valid.
- On a Beat in SHIFT, when bit_sel is not the final index (7, or 0 when MSB_FIRST), bit_sel steps by +1 (or -1 when MSB_FIRST).
- On a Beat in SHIFT at the final index:
  - PARITY_EN=1: go to PARITY.
  - PARITY_EN=0, with a simultaneous Load: reload data_q and bit_sel, stay in SHIFT.
  - PARITY_EN=0, no Load: go to IDLE and drop ser_valid.
- On a Beat in PARITY: take the same reload-or-IDLE decision as above.
- ser_last = (state==SHIFT && final index && !PARITY_EN) || (state==PARITY).
- din is ignored unless din_ready is high. data_q is never modified mid-word.
- Reset asserted mid-word: the word is discarded immediately (asynchronously) and all outputs return to reset values. No partial beat is emitted after release.
- din_valid held high while busy: no effect until din_ready.

Decomposition:
- Shared package `ser_pkg`:
  - state encoding localparams: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2;
  - BIT_FIRST/BIT_FINAL helper constants derived from MSB_FIRST.
- One sub-module: the existing `mux_8x1` is instantiated for bit selection (in=data_q, sel=bit_sel). Counter, FSM and handshake logic live in mux_serializer.

Test Plan:
- Basic, LSB first: default params, din=8'hA5 loaded, ser_ready=1 constant.
  - Required: ser_out sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after load; ser_last on the 8th beat only; ser_valid=0 and busy=0 afterwards.
- MSB_FIRST=1: din=8'hA5.
  - Required: sequence 1,0,1,0,0,1,0,1 with bit_sel 7→0. Also din=8'h01: seven 0s then 1 with ser_last.
- Backpressure: din=8'h3C, ser_ready low for 3 cycles at bit_sel=2.
  - Required: ser_out=1 and bit_sel=2 held stable for all 3 cycles; total 11 cycles from first valid to last beat.
- Back-to-back: din=8'hFF then 8'h00 with din_valid continuously high.
  - Required: din_ready pulses high with the 8th beat; 16 contiguous valid beats (8 ones, 8 zeros); no idle cycle between words.
- Parity: PARITY_EN=1, din=8'h07.
  - Required: 9 beats; 9th beat ser_out=1 (odd count → parity 1) with ser_last. din=8'h03 gives 9th bit 0.
- Reset mid-word: assert rst_n=0 asynchronously (between edges) during bit 4 of 8'hA5.
  - Required: ser_valid, busy and bit_sel go to 0 immediately; din_ready=1 after release; next word 8'h5A serializes cleanly from bit 0.
